// File: rtl/lagd_pll_cfg_ctrl.sv
`timescale 1ns/1ps
// lagd_pll_cfg_ctrl
// Pad-driven PLL configuration controller. A configuration word is shifted in
// MSB first on rising edges of the synchronised strobe pad. It is committed on a
// rising edge of the commit pad, which then sequences PLL reset, lock wait and
// the core clock switch-over.
// Pad protocol: a strobe or commit "event" is a rising edge seen after
// synchronisation. There is no back-pressure. A commit that arrives with the
// wrong bit count, or while the sequencer is busy, is dropped and flagged on
// err_o.
module lagd_pll_cfg_ctrl #(
    parameter int unsigned          CfgWidth    = 32,
    parameter logic [CfgWidth-1:0]  CfgRstVal   = '0,
    parameter int unsigned          SyncStages  = 2,
    parameter int unsigned          RstCycles   = 16,
    parameter int unsigned          LockTimeout = 4096
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                pll_strb_i,
    input  logic                pll_data_i,
    input  logic                pll_cfg_vld_strb_i,
    output logic                pll_data_o,
    input  logic                pll_lock_i,
    output logic [CfgWidth-1:0] pll_cfg_o,
    output logic                pll_rst_o,
    output logic                clk_sel_o,
    output logic                busy_o,
    output logic                err_o
);

    // Bit counter holds 0..CfgWidth+1; CfgWidth+1 is the sticky overflow value.
    localparam int unsigned CntW = $clog2(CfgWidth + 2);
    localparam int unsigned RstW = $clog2(RstCycles + 1);
    localparam int unsigned ToW  = $clog2(LockTimeout + 1);

    localparam logic [CntW-1:0] CntFull = CntW'(CfgWidth);
    localparam logic [CntW-1:0] CntSat  = CntW'(CfgWidth + 1);
    localparam logic [RstW-1:0] RstLast = RstW'(RstCycles - 1);
    localparam logic [ToW-1:0]  ToLast  = ToW'(LockTimeout - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET     = 3'd1,
        S_LOCK_WAIT = 3'd2,
        S_LOCKED    = 3'd3,
        S_FAIL      = 3'd4
    } state_e;

    // Synchroniser: one 4-bit lane group per stage {lock, commit, data, strobe}.
    logic [SyncStages-1:0][3:0] r_sync;
    logic                       r_strb_q;
    logic                       r_vld_q;
    logic [CfgWidth-1:0]        r_sr;
    logic [CntW-1:0]            r_bit_cnt;
    logic [CfgWidth-1:0]        r_cfg;
    logic                       r_err;
    state_e                     r_state;
    logic [RstW-1:0]            r_rst_cnt;
    logic [ToW-1:0]             r_to_cnt;
    logic                       r_pll_rst;
    logic                       r_clk_sel;
    logic                       r_busy;

    logic                       w_strb_s;
    logic                       w_data_s;
    logic                       w_vld_s;
    logic                       w_lock_s;
    logic                       w_strb_rise;
    logic                       w_vld_rise;
    logic [CfgWidth-1:0]        w_sr_upd;
    logic [CntW-1:0]            w_cnt_upd;
    logic                       w_can_commit;
    logic                       w_accept;
    logic                       w_reject;
    logic                       w_fault;
    state_e                     w_state_nxt;
    logic [RstW-1:0]            w_rst_cnt_nxt;
    logic [ToW-1:0]             w_to_cnt_nxt;

    assign w_strb_s = r_sync[SyncStages-1][0];
    assign w_data_s = r_sync[SyncStages-1][1];
    assign w_vld_s  = r_sync[SyncStages-1][2];
    assign w_lock_s = r_sync[SyncStages-1][3];

    assign w_strb_rise = w_strb_s & ~r_strb_q;
    assign w_vld_rise  = w_vld_s  & ~r_vld_q;

    // A coincident strobe is applied before the commit looks at sr/bit_cnt.
    assign w_sr_upd  = w_strb_rise ? {r_sr[CfgWidth-2:0], w_data_s} : r_sr;
    assign w_cnt_upd = (w_strb_rise && (r_bit_cnt != CntSat)) ? r_bit_cnt + 1'b1 : r_bit_cnt;

    assign w_can_commit = (r_state == S_IDLE) || (r_state == S_LOCKED) || (r_state == S_FAIL);
    assign w_accept     = w_vld_rise && (w_cnt_upd == CntFull) && w_can_commit;
    assign w_reject     = w_vld_rise && !w_accept;

    // Pad synchroniser chains and edge-detect history
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync   <= '0;
            r_strb_q <= 1'b0;
            r_vld_q  <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SyncStages-2:0],
                         {pll_lock_i, pll_cfg_vld_strb_i, pll_data_i, pll_strb_i}};
            r_strb_q <= w_strb_s;
            r_vld_q  <= w_vld_s;
        end
    end

    // Shift register and bit counter; every commit edge restarts the count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_sr      <= w_sr_upd;
            r_bit_cnt <= w_vld_rise ? '0 : w_cnt_upd;
        end
    end

    // Active configuration and sticky error flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cfg <= CfgRstVal;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cfg <= w_sr_upd;
                r_err <= 1'b0;
            end else if (w_reject || w_fault) begin
                r_err <= 1'b1;
            end
        end
    end

    // Sequencer state and its counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_rst_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rst_cnt <= w_rst_cnt_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
        end
    end

    // Sequencer next state: reset pulse, lock wait with timeout, lock monitor
    always_comb begin
        w_state_nxt   = r_state;
        w_rst_cnt_nxt = r_rst_cnt;
        w_to_cnt_nxt  = r_to_cnt;
        w_fault       = 1'b0;
        unique case (r_state)
            S_IDLE, S_FAIL: begin
            end
            S_RESET: begin
                if (r_rst_cnt == RstLast) begin
                    w_state_nxt  = S_LOCK_WAIT;
                    w_to_cnt_nxt = '0;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + 1'b1;
                end
            end
            S_LOCK_WAIT: begin
                if (w_lock_s) begin
                    w_state_nxt = S_LOCKED;
                end else if (r_to_cnt == ToLast) begin
                    w_state_nxt = S_FAIL;
                    w_fault     = 1'b1;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
            end
            S_LOCKED: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_FAIL;
                    w_fault     = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // An accepted commit restarts the whole sequence from any idle-like state.
        if (w_accept) begin
            w_state_nxt   = S_RESET;
            w_rst_cnt_nxt = '0;
        end
    end

    // Registered control outputs, decoded from the next state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pll_rst <= 1'b1;
            r_clk_sel <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_pll_rst <= !((w_state_nxt == S_LOCK_WAIT) || (w_state_nxt == S_LOCKED));
            r_clk_sel <= (w_state_nxt == S_LOCKED);
            r_busy    <= (w_state_nxt == S_RESET) || (w_state_nxt == S_LOCK_WAIT);
        end
    end

    assign pll_data_o = r_sr[CfgWidth-1];
    assign pll_cfg_o  = r_cfg;
    assign pll_rst_o  = r_pll_rst;
    assign clk_sel_o  = r_clk_sel;
    assign busy_o     = r_busy;
    assign err_o      = r_err;

endmodule

// File: tb/tb_lagd_pll_cfg_ctrl.sv
`timescale 1ns/1ps
// Testbench for lagd_pll_cfg_ctrl: directed pad sequences, expectations queued
// by the driver and compared by a separate monitor on the falling clock edge.
module tb_lagd_pll_cfg_ctrl;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         strb = 1'b0;
  logic         data = 1'b0;
  logic         vld  = 1'b0;
  logic         lock = 1'b0;
  logic         data_o;
  logic [W-1:0] cfg_o;
  logic         rst_o;
  logic         sel_o;
  logic         busy_o;
  logic         err_o;

  lagd_pll_cfg_ctrl dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .pll_strb_i         (strb),
    .pll_data_i         (data),
    .pll_cfg_vld_strb_i (vld),
    .pll_data_o         (data_o),
    .pll_lock_i         (lock),
    .pll_cfg_o          (cfg_o),
    .pll_rst_o          (rst_o),
    .clk_sel_o          (sel_o),
    .busy_o             (busy_o),
    .err_o              (err_o)
  );

  // ---------------- scoreboard ----------------
  // sig: 0 cfg, 1 pll_rst, 2 clk_sel, 3 busy, 4 err, 5 data_o, 6 measured value
  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
    logic [31:0] meas;
  } chk_t;

  chk_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic expect_sig(input string name, input int sig, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sig  = sig;
    c.exp  = exp;
    c.meas = 32'h0;
    exp_q.push_back(c);
  endtask

  task automatic expect_meas(input string name, input logic [31:0] meas, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sig  = 6;
    c.exp  = exp;
    c.meas = meas;
    exp_q.push_back(c);
  endtask

  task automatic expect_outs(input string tag, input logic [31:0] cfg, input logic r,
                             input logic s, input logic b, input logic e);
    expect_sig({tag, "_cfg"},   0, cfg);
    expect_sig({tag, "_rst"},   1, {31'b0, r});
    expect_sig({tag, "_sel"},   2, {31'b0, s});
    expect_sig({tag, "_busy"},  3, {31'b0, b});
    expect_sig({tag, "_err"},   4, {31'b0, e});
  endtask

  // Monitor: pops every queued expectation and compares against the DUT
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      case (c.sig)
        0:       act = cfg_o;
        1:       act = {31'b0, rst_o};
        2:       act = {31'b0, sel_o};
        3:       act = {31'b0, busy_o};
        4:       act = {31'b0, err_o};
        5:       act = {31'b0, data_o};
        default: act = c.meas;
      endcase
      n_vec++;
      if (act !== c.exp) begin
        n_err++;
        $display("FAIL %s: got %0h expected %0h", c.name, act, c.exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    data = b;
    strb = 1'b1;
    tick(4);
    strb = 1'b0;
    tick(4);
  endtask

  // Shift the low n bits of word, MSB first; optionally check readback of prev.
  task automatic shift_word(input logic [63:0] word, input int n, input bit chk_rb,
                            input logic [31:0] prev);
    for (int i = n - 1; i >= 0; i--) begin
      if (chk_rb) expect_sig("readback", 5, {31'b0, prev[i]});
      send_bit(word[i]);
    end
  endtask

  task automatic commit();
    vld = 1'b1;
    tick(4);
    vld = 1'b0;
    tick(4);
  endtask

  // Commit and count cycles spent in RESET (busy with pll_rst high); returns
  // once the first LOCK_WAIT cycle is observed.
  task automatic commit_measure(input string name);
    int rc;
    rc  = 0;
    vld = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      tick(1);
      if (k == 4) vld = 1'b0;
      if (busy_o && rst_o) rc++;
      else if (busy_o && !rst_o) break;
    end
    vld = 1'b0;
    expect_meas(name, rc, 16);
  endtask

  // Cycles from now until clk_sel_o reaches val (bounded)
  task automatic cycles_to_sel(input logic val, output int cnt);
    cnt = 0;
    do begin
      tick(1);
      cnt++;
    end while (sel_o !== val && cnt < 40);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int lw;

    // Reset state
    tick(3);
    expect_outs("reset", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_sig("reset_data", 5, 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Load and commit 0xA5C30F1E from IDLE
    shift_word(64'hA5C3_0F1E, 32, 1'b0, 32'h0);
    commit_measure("rst_len_idle");
    expect_outs("lockwait", 32'hA5C3_0F1E, 1'b0, 1'b0, 1'b1, 1'b0);

    // Lock arrives during LOCK_WAIT
    tick(5);
    lock = 1'b1;
    cycles_to_sel(1'b1, c);
    expect_meas("lock_latency", c, 3);
    expect_outs("locked", 32'hA5C3_0F1E, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(5);

    // Lock loss in LOCKED -> FAIL
    lock = 1'b0;
    cycles_to_sel(1'b0, c);
    expect_meas("unlock_latency", c, 3);
    expect_outs("lockloss", 32'hA5C3_0F1E, 1'b1, 1'b0, 1'b0, 1'b1);

    // Readback of previous word while shifting a new one, then commit from FAIL
    shift_word(64'h1234_5678, 32, 1'b1, 32'hA5C3_0F1E);
    expect_sig("readback_new_msb", 5, 32'h0);
    commit_measure("rst_len_fail");
    expect_outs("recommit", 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0);

    // Commit in LOCK_WAIT coincident with the 32nd strobe -> rejected, sequence continues
    shift_word(64'h5555_AAAA, 31, 1'b0, 32'h0);
    data = 1'b0;
    strb = 1'b1;
    vld  = 1'b1;
    tick(4);
    strb = 1'b0;
    vld  = 1'b0;
    tick(4);
    expect_outs("busy_reject", 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b1);

    // Ride out the remaining timeout
    c = 0;
    while (busy_o && c < 5000) begin
      tick(1);
      c++;
    end
    expect_outs("timeout1", 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b1);

    // Exact LOCK_WAIT duration without lock
    shift_word(64'h0F0F_F0F0, 32, 1'b0, 32'h0);
    commit_measure("rst_len_fail2");
    lw = 1;
    for (int k = 0; k < 5000; k++) begin
      tick(1);
      if (busy_o && !rst_o) lw++;
      else break;
    end
    expect_meas("lockwait_len", lw, 4096);
    expect_outs("timeout2", 32'h0F0F_F0F0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reach LOCKED again
    shift_word(64'hCAFE_BABE, 32, 1'b0, 32'h0);
    commit_measure("rst_len_fail3");
    lock = 1'b1;
    cycles_to_sel(1'b1, c);
    expect_meas("lock_latency2", c, 3);
    expect_outs("locked2", 32'hCAFE_BABE, 1'b0, 1'b1, 1'b0, 1'b0);

    // 31-bit commit rejected, state untouched
    shift_word(64'h7FFF_FFFF, 31, 1'b0, 32'h0);
    commit();
    expect_outs("short_reject", 32'hCAFE_BABE, 1'b0, 1'b1, 1'b0, 1'b1);

    // Correct commit from LOCKED clears err; pll_rst pulses for RstCycles
    shift_word(64'h600D_F00D, 32, 1'b0, 32'h0);
    commit_measure("rst_len_locked");
    tick(3);
    expect_outs("relock", 32'h600D_F00D, 1'b0, 1'b1, 1'b0, 1'b0);

    // 33-bit commit rejected
    shift_word(64'h1_0000_0001, 33, 1'b0, 32'h0);
    commit();
    expect_outs("long_reject", 32'h600D_F00D, 1'b0, 1'b1, 1'b0, 1'b1);

    // Correct commit clears err
    shift_word(64'h1357_9BDF, 32, 1'b0, 32'h0);
    commit_measure("rst_len_locked2");
    tick(3);
    expect_outs("clear_err", 32'h1357_9BDF, 1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of RESET
    shift_word(64'hE468_ACE1, 32, 1'b0, 32'h0);
    commit();
    expect_outs("mid_reset_pre", 32'hE468_ACE1, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_sig("mid_reset_pre_data", 5, 32'h1);
    tick(1);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (rst_o !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset_imm_rst: got %0h expected 1", rst_o);
    end
    n_vec++;
    if (sel_o !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_imm_sel: got %0h expected 0", sel_o);
    end
    n_vec++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_imm_busy: got %0h expected 0", busy_o);
    end
    n_vec++;
    if (err_o !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_imm_err: got %0h expected 0", err_o);
    end
    n_vec++;
    if (cfg_o !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset_imm_cfg: got %0h expected 0", cfg_o);
    end
    n_vec++;
    if (data_o !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_imm_data: got %0h expected 0", data_o);
    end
    expect_outs("async_reset", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_sig("async_reset_data", 5, 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: got %0d pending expected 0", exp_q.size());
    end
    if (n_err == 0) $display("PASS: all checks passed");
    else            $display("FAIL: %0d miscompares", n_err);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lagd_pll_cfg_ctrl.md
# lagd_pll_cfg_ctrl

Pad-driven configuration controller for the chip PLL. It deserialises a configuration word from the external strobe/data pads and commits it on the config-valid strobe. It then sequences PLL reset, lock acquisition and the switch of the core clock from the reference clock to the PLL output. It sits in the chip top between the PLL configuration pads and the PLL macro/clock mux, ahead of `lagd_soc`, and must be usable before the SoC or JTAG is alive.

## Interface

Parameters:
- `CfgWidth`, 32: configuration word width in bits.
- `CfgRstVal`, `'0`: value of `pll_cfg_o` after reset.
- `SyncStages`, 2: synchroniser depth for all asynchronous pad inputs, minimum 2.
- `RstCycles`, 16: PLL reset pulse length in `clk_i` cycles, minimum 1.
- `LockTimeout`, 4096: maximum `clk_i` cycles spent waiting for lock.

Ports:
- `clk_i`, in, 1: reference clock; always running and never the PLL output.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `pll_strb_i`, in, 1: shift strobe from pad, asynchronous.
- `pll_data_i`, in, 1: serial data from pad, sampled on the strobe rising edge, MSB first.
- `pll_cfg_vld_strb_i`, in, 1: commit strobe from pad, asynchronous.
- `pll_data_o`, out, 1: serial readback equal to shift register bit `[CfgWidth-1]`.
- `pll_lock_i`, in, 1: PLL lock indicator, asynchronous.
- `pll_cfg_o`, out, `CfgWidth`: active PLL configuration.
- `pll_rst_o`, out, 1: PLL reset, active-high.
- `clk_sel_o`, out, 1: clock mux select; 0 selects the reference clock, 1 selects the PLL clock.
- `busy_o`, out, 1: high while in RESET or LOCK_WAIT.
- `err_o`, out, 1: sticky error flag.

## Operation

- All three asynchronous inputs pass through `SyncStages` flip-flops. A registered previous value then provides rising-edge detection for both strobes.
- Strobe rising edge:
  - `sr <= {sr[CfgWidth-2:0], data_sync}`.
  - `bit_cnt` increments and saturates at `CfgWidth+1`; the saturated value means overflow.
- Commit rising edge:
  - Accepted if `bit_cnt == CfgWidth` and state is IDLE, LOCKED or FAIL.
  - Rejected otherwise. A rejected commit sets `err_o` and leaves `pll_cfg_o` and the state untouched.
  - `bit_cnt` clears on every commit edge, accepted or rejected.
- Simultaneous strobe and commit edges in the same cycle: the shift and count are applied first. The commit then evaluates the updated count and commits the updated `sr`.
- An accepted commit loads `pll_cfg_o <= sr`, clears `err_o` and enters RESET.
- FSM (reset state IDLE):
  - IDLE: `pll_rst_o=1`, `clk_sel_o=0`.
  - RESET: `pll_rst_o=1`, `clk_sel_o=0`. Counts `RstCycles`, then enters LOCK_WAIT.
  - LOCK_WAIT: `pll_rst_o=0`, `clk_sel_o=0`. Enters LOCKED when the synchronised lock is 1. Enters FAIL and sets `err_o` when the timeout counter reaches `LockTimeout-1` without lock.
  - LOCKED: `pll_rst_o=0`, `clk_sel_o=1`. If the synchronised lock drops to 0, enters FAIL and sets `err_o`.
  - FAIL: `pll_rst_o=1`, `clk_sel_o=0`. Leaves only via an accepted commit.
- The readback output is the shift register MSB. After loading a word, clocking `CfgWidth` further strobes returns that word MSB first on `pll_data_o`.

## Timing

- Reset values:
  - `pll_cfg_o=CfgRstVal`, `pll_rst_o=1`, `clk_sel_o=0`, `busy_o=0`, `err_o=0`, `pll_data_o=0`.
  - Internally, `sr=0` and `bit_cnt=0`.
- Pad-to-edge latency is `SyncStages+1` cycles. Strobe high and low phases must each last at least `SyncStages+1` `clk_i` cycles; shorter pulses are not guaranteed to be counted.
- Commit detected in cycle N: `pll_cfg_o`, `busy_o=1` and `pll_rst_o=1` are valid at N+1, and `clk_sel_o=0` from N+1 onward.
- `pll_rst_o` stays high for exactly `RstCycles` cycles after an accepted commit issued from LOCKED. From IDLE or FAIL it was already high, so `RstCycles` counts from N+1.
- The LOCK_WAIT timeout counter starts at 0 on entry.
- Lock seen on the synchroniser output in cycle M gives `clk_sel_o=1` and `busy_o=0` at M+1.
- Lock loss follows the same path: `clk_sel_o=0` and `pll_rst_o=1` one cycle after the synchronised drop.
- An asynchronous reset mid-sequence immediately forces all outputs to their reset values.
- All outputs are registered.

## Test plan

- Shift in `0xA5C3_0F1E` (32 strobes), then commit -> `pll_cfg_o=0xA5C30F1E`; `pll_rst_o` high for exactly 16 cycles; `busy_o=1` throughout RESET and LOCK_WAIT.
- Drive `pll_lock_i=1` 100 cycles after reset release -> `clk_sel_o=1` within `SyncStages+2` cycles; `err_o=0`.
- Shift 31 bits and commit, then separately shift 33 bits and commit -> both rejected: `err_o=1`, `pll_cfg_o` unchanged; a following correct 32-bit commit clears `err_o`.
- Keep `pll_lock_i=0` -> FAIL after 4096 LOCK_WAIT cycles: `err_o=1`, `pll_rst_o=1`, `clk_sel_o=0`.
- In LOCKED, drop `pll_lock_i` -> `clk_sel_o=0` and `err_o=1`. Then shift 32 strobes of `0x1234_5678` -> `pll_data_o` emits the previous word `0xA5C30F1E`, MSB first.
- Commit during LOCK_WAIT with the 32nd strobe edge coincident with the commit edge -> rejected due to busy, `err_o=1`, and the sequence continues. Assert `rst_ni` mid-RESET -> all outputs return to their reset values.
